// File: rtl/snapshot_pkg.sv
// Shared sizing constants and the stored snapshot type for the sensor snapshot buffer.
package snapshot_pkg;

    localparam int SNAP_DEPTH  = 8;
    localparam int SNAP_DATA_W = 24;
    localparam int SNAP_PTR_W  = $clog2(SNAP_DEPTH);

    typedef logic [SNAP_DATA_W-1:0] snap_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for a level from a foreign clock domain, followed by a
// rise detector that gives one pulse per 0->1 transition of the synchronised level.
module edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic level_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= level_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/sensor_snapshot_buffer.sv
// Circular store of sensor snapshots: save events write the newest slot, load
// events walk back from newest to oldest and wrap to the newest again.
module sensor_snapshot_buffer
    import snapshot_pkg::*;
#(
    parameter int DEPTH  = SNAP_DEPTH,
    parameter int DATA_W = SNAP_DATA_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [31:0]                sensor_input_to_save,
    input  logic [31:0]                save_signal,
    input  logic [31:0]                load_signal,
    output logic [31:0]                recalled_data,
    output logic                       recall_valid,
    output logic                       recall_miss,
    output logic [$clog2(DEPTH):0]     snapshot_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic saveRise;
    logic loadRise;

    logic [PTR_W-1:0]  wrPtr_q,  wrPtr_d;
    logic [PTR_W-1:0]  cursor_q, cursor_d;
    logic [PTR_W-1:0]  steps_q,  steps_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [31:0]       recalledData_q, recalledData_d;
    logic              recallValid_q,  recallValid_d;
    logic              recallMiss_q,   recallMiss_d;
    logic              memWrite;

    logic [DATA_W-1:0] mem [DEPTH];

    edge_sync u_saveSync (
        .clock   (clock),
        .reset   (reset),
        .level_i (save_signal[0]),
        .rise_o  (saveRise)
    );

    edge_sync u_loadSync (
        .clock   (clock),
        .reset   (reset),
        .level_i (load_signal[0]),
        .rise_o  (loadRise)
    );

    // A save takes priority; a load rising in the same cycle is dropped.
    always_comb begin
        wrPtr_d        = wrPtr_q;
        cursor_d       = cursor_q;
        steps_d        = steps_q;
        count_d        = count_q;
        recalledData_d = recalledData_q;
        recallValid_d  = 1'b0;
        recallMiss_d   = 1'b0;
        memWrite       = 1'b0;
        if (saveRise) begin
            memWrite = 1'b1;
            wrPtr_d  = wrPtr_q + PTR_W'(1);
            cursor_d = wrPtr_q;
            steps_d  = '0;
            if (count_q != FULL_COUNT) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (loadRise) begin
            if (count_q == '0) begin
                recallMiss_d = 1'b1;
            end else begin
                recallValid_d                = 1'b1;
                recalledData_d               = '0;
                recalledData_d[DATA_W-1:0]   = mem[cursor_q];
                if ({1'b0, steps_q} == count_q - CNT_W'(1)) begin
                    cursor_d = wrPtr_q - PTR_W'(1);
                    steps_d  = '0;
                end else begin
                    cursor_d = cursor_q - PTR_W'(1);
                    steps_d  = steps_q + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr_q        <= '0;
            cursor_q       <= '0;
            steps_q        <= '0;
            count_q        <= '0;
            recalledData_q <= '0;
            recallValid_q  <= 1'b0;
            recallMiss_q   <= 1'b0;
        end else begin
            wrPtr_q        <= wrPtr_d;
            cursor_q       <= cursor_d;
            steps_q        <= steps_d;
            count_q        <= count_d;
            recalledData_q <= recalledData_d;
            recallValid_q  <= recallValid_d;
            recallMiss_q   <= recallMiss_d;
        end
    end

    // Storage is deliberately left unreset; count = 0 makes stale slots unreachable.
    always_ff @(posedge clock) begin
        if (memWrite) begin
            mem[wrPtr_q] <= sensor_input_to_save[DATA_W-1:0];
        end
    end

    generate
        if (DATA_W < 32) begin : g_unusedData
            logic unusedBits;
            assign unusedBits = ^{sensor_input_to_save[31:DATA_W], save_signal[31:1], load_signal[31:1]};
        end else begin : g_unusedCtrl
            logic unusedBits;
            assign unusedBits = ^{save_signal[31:1], load_signal[31:1]};
        end
    endgenerate

    assign recalled_data  = recalledData_q;
    assign recall_valid   = recallValid_q;
    assign recall_miss    = recallMiss_q;
    assign snapshot_count = count_q;

endmodule
